// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants and FSM encoding for the interrupt controller
// Contents: register byte offsets inside the 32-byte window, TCON bit
// positions, and the request/service FSM state encoding.
package irq_ctrl_pkg;

    localparam logic [4:0] OFF_TH    = 5'h00;
    localparam logic [4:0] OFF_TL    = 5'h04;
    localparam logic [4:0] OFF_TCON  = 5'h08;
    localparam logic [4:0] OFF_IMASK = 5'h0C;
    localparam logic [4:0] OFF_IPEND = 5'h10;
    localparam logic [4:0] OFF_ISRC  = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_TF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SIGNAL  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - data-bus, interrupt-line and core-handshake bundle
// Signals: addr/wdata/rd/wr/rdata (data-memory bus), ext_irq (external
// level requests), irq_ack/irq_done (core handshake), irq/irq_id (request).
// master = core/bus side, slave = controller side.
interface irq_controller_if #(
    parameter int NUM_SRC = 4
);
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic               rd;
    logic               wr;
    logic [31:0]        rdata;
    logic [NUM_SRC-2:0] ext_irq;
    logic               irq_ack;
    logic               irq_done;
    logic               irq;
    logic [4:0]         irq_id;

    modport master (
        output addr, wdata, rd, wr, ext_irq, irq_ack, irq_done,
        input  rdata, irq, irq_id
    );

    modport slave (
        input  addr, wdata, rd, wr, ext_irq, irq_ack, irq_done,
        output rdata, irq, irq_id
    );
endinterface

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - reloadable 32-bit timer (TH/TL/TCON), built only with IRQ_TIMER_EN
// Ports: clk, reset (async active-low), wr_th/wr_tl/wr_tcon (decoded write
// strobes), wdata; th, tl, tcon {TF,IE,EN}, ovf_irq (combinational request
// to set pend[0] on the overflowing edge).
module irq_timer
    import irq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        ovf_irq
);
    logic en;
    logic ie;
    logic tf;
    logic wrap;

    assign wrap    = en && (tl == 32'hFFFF_FFFF);
    assign ovf_irq = wrap && ie;
    assign tcon    = {tf, ie, en};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
            tl <= '0;
            en <= 1'b0;
            ie <= 1'b0;
            tf <= 1'b0;
        end else begin
            if (wr_th)
                th <= wdata;
            // Software write to TL beats both reload and increment.
            if (wr_tl)
                tl <= wdata;
            else if (wrap)
                tl <= th;
            else if (en)
                tl <= tl + 32'd1;
            if (wr_tcon) begin
                en <= wdata[TCON_EN];
                ie <= wdata[TCON_IE];
            end
            // W1C on TF; an overflow in the same cycle keeps it set.
            tf <= (tf & ~(wr_tcon & wdata[TCON_TF])) | wrap;
        end
    end
endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - memory-mapped interrupt controller with one outstanding request
// Ports: clk, reset (async active-low), bus (irq_controller_if.slave:
// addr/wdata/rd/wr/rdata, ext_irq, irq_ack, irq_done, irq, irq_id).
// Parameters: NUM_SRC (source 0 = timer, 1..NUM_SRC-1 external), BASE_ADDR.
// Build option: IRQ_TIMER_EN includes the timer; without it source 0 is dead.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic             clk,
    input  logic             reset,
    irq_controller_if.slave  bus
);
    localparam logic [NUM_SRC-1:0] ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};
`ifdef IRQ_TIMER_EN
    localparam logic [NUM_SRC-1:0] VALID = '1;
`else
    localparam logic [NUM_SRC-1:0] VALID = ~ONE;
`endif

    logic               in_win;
    logic [4:0]         off;
    logic               wr_hit;
    logic [31:0]        th, tl;
    logic [2:0]         tcon;
    logic               tmr_set;
    logic [NUM_SRC-2:0] sync1, sync2, prev;
    logic [NUM_SRC-2:0] ext_rise;
    logic [NUM_SRC-1:0] pend, imask, req, clr_vec, ack_clr;
    logic [4:0]         low_id;
    logic               ack_take;
    state_t             state;
    logic               irq_r;
    logic [4:0]         irq_id_r;
    logic               unused_bits;

    assign in_win = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign off    = {bus.addr[4:2], 2'b00};
    assign wr_hit = bus.wr && in_win;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

`ifdef IRQ_TIMER_EN
    irq_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr_hit && off == OFF_TH),
        .wr_tl   (wr_hit && off == OFF_TL),
        .wr_tcon (wr_hit && off == OFF_TCON),
        .wdata   (bus.wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .ovf_irq (tmr_set)
    );
`else
    assign th      = '0;
    assign tl      = '0;
    assign tcon    = '0;
    assign tmr_set = 1'b0;
`endif

    // Two-flop synchroniser followed by a rising-edge detector per line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= bus.ext_irq;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end
    assign ext_rise = sync2 & ~prev;

    assign ack_take = (state == ST_SIGNAL) && bus.irq_ack;
    assign ack_clr  = ack_take ? (ONE << irq_id_r) : '0;
    assign clr_vec  = ack_clr |
                      ((wr_hit && off == OFF_IPEND) ? bus.wdata[NUM_SRC-1:0] : '0);

    // Sets are applied after clears so a same-cycle set always survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend  <= '0;
            imask <= '0;
        end else begin
            pend <= ((pend & ~clr_vec) | {ext_rise, tmr_set}) & VALID;
            if (wr_hit && off == OFF_IMASK)
                imask <= bus.wdata[NUM_SRC-1:0] & VALID;
        end
    end

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        req    = pend & imask;
        low_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i])
                low_id = 5'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            irq_r    <= 1'b0;
            irq_id_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        irq_id_r <= low_id;
                        irq_r    <= 1'b1;
                        state    <= ST_SIGNAL;
                    end
                end
                ST_SIGNAL: begin
                    if (bus.irq_ack) begin
                        irq_r <= 1'b0;
                        state <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (bus.irq_done)
                        state <= ST_IDLE;
                end
                default: begin
                    irq_r <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.irq    = irq_r;
    assign bus.irq_id = irq_id_r;

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && in_win) begin
            case (off)
                OFF_TH:    bus.rdata = th;
                OFF_TL:    bus.rdata = tl;
                OFF_TCON:  bus.rdata = {29'b0, tcon};
                OFF_IMASK: bus.rdata = 32'(imask);
                OFF_IPEND: bus.rdata = 32'(pend);
                OFF_ISRC:  bus.rdata = {27'b0, irq_id_r};
                default:   bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed scoreboard bench for irq_controller
module tb_irq_controller;
    import irq_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef IRQ_TIMER_EN
    localparam logic [31:0] VM = 32'hF;
`else
    localparam logic [31:0] VM = 32'hE;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    irq_controller_if #(.NUM_SRC(4)) bif ();

    irq_controller #(.NUM_SRC(4), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string t, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic wr_reg(input logic [4:0] o, input logic [31:0] d);
        bif.addr  = BASE + 32'(o);
        bif.wdata = d;
        bif.wr    = 1'b1;
        step(1);
        bif.wr    = 1'b0;
        bif.addr  = '0;
        bif.wdata = '0;
    endtask

    task automatic rd_reg(input logic [4:0] o, output logic [31:0] d);
        bif.addr = BASE + 32'(o);
        bif.rd   = 1'b1;
        #1;
        d        = bif.rdata;
        bif.rd   = 1'b0;
        bif.addr = '0;
    endtask

    task automatic pop_reg(input logic [4:0] o);
        logic [31:0] d;
        rd_reg(o, d);
        pop_chk(d);
    endtask

    task automatic chk_reg(input string t, input logic [4:0] o, input logic [31:0] e);
        push_exp(t, e);
        pop_reg(o);
    endtask

    task automatic chk_sig(input string t, input logic [31:0] obs, input logic [31:0] e);
        push_exp(t, e);
        pop_chk(obs);
    endtask

    task automatic pulse_ack();
        bif.irq_ack = 1'b1;
        step(1);
        bif.irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        bif.irq_done = 1'b1;
        step(1);
        bif.irq_done = 1'b0;
    endtask

    initial begin
        bif.addr     = '0;
        bif.wdata    = '0;
        bif.rd       = 1'b0;
        bif.wr       = 1'b0;
        bif.ext_irq  = '0;
        bif.irq_ack  = 1'b0;
        bif.irq_done = 1'b0;
        reset        = 1'b0;
        step(2);

        chk_sig("rst_irq", 32'(bif.irq), 32'd0);
        chk_sig("rst_id", 32'(bif.irq_id), 32'd0);
        chk_reg("rst_ipend", OFF_IPEND, 32'd0);
        chk_reg("rst_imask", OFF_IMASK, 32'd0);
        reset = 1'b1;
        step(1);

        wr_reg(OFF_IMASK, 32'hF);
        chk_reg("imask_rb", OFF_IMASK, VM);
        chk_reg("tcon_rst", OFF_TCON, 32'd0);
        bif.addr = BASE + 32'h20;
        bif.rd   = 1'b1;
        #1;
        chk_sig("out_window", bif.rdata, 32'd0);
        bif.rd   = 1'b0;
        bif.addr = '0;
        step(1);

`ifdef IRQ_TIMER_EN
        wr_reg(OFF_IMASK, 32'h1);
        wr_reg(OFF_TH, 32'hFFFF_FFFC);
        wr_reg(OFF_TL, 32'hFFFF_FFFC);
        wr_reg(OFF_TCON, 32'h3);
        chk_reg("tl_start", OFF_TL, 32'hFFFF_FFFC);
        step(3);
        chk_reg("tl_max", OFF_TL, 32'hFFFF_FFFF);
        chk_sig("tmr_irq_pre", 32'(bif.irq), 32'd0);
        step(1);
        chk_reg("tl_reload", OFF_TL, 32'hFFFF_FFFC);
        chk_reg("tcon_tf", OFF_TCON, 32'h7);
        chk_reg("tmr_pend", OFF_IPEND, 32'h1);
        chk_sig("tmr_irq_lat", 32'(bif.irq), 32'd0);
        step(1);
        chk_sig("tmr_irq", 32'(bif.irq), 32'd1);
        chk_sig("tmr_id", 32'(bif.irq_id), 32'd0);
        pulse_ack();
        chk_sig("tmr_ack_irq", 32'(bif.irq), 32'd0);
        chk_reg("tmr_ack_pend", OFF_IPEND, 32'd0);
        wr_reg(OFF_TCON, 32'h7);
        chk_reg("tf_clear", OFF_TCON, 32'h3);
        chk_reg("tl_max2", OFF_TL, 32'hFFFF_FFFF);
        wr_reg(OFF_TCON, 32'h0);
        chk_reg("tf_set_wins", OFF_TCON, 32'h4);
        chk_reg("tmr_pend2", OFF_IPEND, 32'h1);
        chk_sig("svc_no_irq", 32'(bif.irq), 32'd0);
        wr_reg(OFF_IPEND, 32'h1);
        wr_reg(OFF_TCON, 32'h4);
        pulse_done();
        chk_reg("tmr_pend_clr", OFF_IPEND, 32'd0);
        chk_reg("tcon_off", OFF_TCON, 32'd0);
        step(1);
        chk_sig("tmr_quiet", 32'(bif.irq), 32'd0);
        wr_reg(OFF_IMASK, 32'hF);
`else
        wr_reg(OFF_TH, 32'h5);
        chk_reg("th_absent", OFF_TH, 32'd0);
        wr_reg(OFF_TCON, 32'h7);
        chk_reg("tcon_absent", OFF_TCON, 32'd0);
        chk_reg("pend0_absent", OFF_IPEND, 32'd0);
`endif

        // Priority: sources 1 and 3 arrive together.
        bif.ext_irq = 3'b101;
        push_exp("prio_ipend", 32'hA);
        push_exp("prio_irq_pre", 32'd0);
        push_exp("prio_irq", 32'd1);
        push_exp("prio_id", 32'd1);
        step(3);
        pop_reg(OFF_IPEND);
        pop_chk(32'(bif.irq));
        step(1);
        pop_chk(32'(bif.irq));
        pop_chk(32'(bif.irq_id));
        bif.ext_irq = 3'b000;
        pulse_ack();
        chk_sig("prio_ack_irq", 32'(bif.irq), 32'd0);
        chk_reg("prio_ack_pend", OFF_IPEND, 32'h8);
        step(1);
        chk_sig("prio_svc_irq", 32'(bif.irq), 32'd0);
        pulse_done();
        chk_sig("prio_done_irq", 32'(bif.irq), 32'd0);
        step(1);
        chk_sig("prio_re_irq", 32'(bif.irq), 32'd1);
        chk_sig("prio_re_id", 32'(bif.irq_id), 32'd3);
        pulse_ack();
        pulse_done();
        chk_reg("prio_pend_empty", OFF_IPEND, 32'd0);

        // Masking.
        wr_reg(OFF_IMASK, 32'h0);
        bif.ext_irq = 3'b010;
        step(3);
        chk_reg("mask_pend", OFF_IPEND, 32'h4);
        chk_sig("mask_irq0", 32'(bif.irq), 32'd0);
        step(2);
        chk_sig("mask_irq1", 32'(bif.irq), 32'd0);
        wr_reg(OFF_IMASK, 32'h4);
        chk_sig("unmask_pre", 32'(bif.irq), 32'd0);
        step(1);
        chk_sig("unmask_irq", 32'(bif.irq), 32'd1);
        chk_sig("unmask_id", 32'(bif.irq_id), 32'd2);
        pulse_ack();
        chk_reg("unmask_ack_pend", OFF_IPEND, 32'd0);

        // Nesting blocked while in service.
        bif.ext_irq = 3'b011;
        step(5);
        chk_sig("nest_irq", 32'(bif.irq), 32'd0);
        chk_reg("nest_pend", OFF_IPEND, 32'h2);
        wr_reg(OFF_IMASK, 32'hF);
        pulse_done();
        chk_sig("nest_done_irq", 32'(bif.irq), 32'd0);
        step(1);
        chk_sig("nest_re_irq", 32'(bif.irq), 32'd1);
        chk_sig("nest_re_id", 32'(bif.irq_id), 32'd1);
        pulse_ack();
        pulse_done();

        // Stray handshake pulses in IDLE.
        wr_reg(OFF_IMASK, 32'h0);
        bif.ext_irq = 3'b111;
        step(4);
        chk_reg("stray_pend", OFF_IPEND, 32'h8);
        pulse_ack();
        chk_reg("stray_ack_pend", OFF_IPEND, 32'h8);
        chk_sig("stray_ack_irq", 32'(bif.irq), 32'd0);
        pulse_done();
        step(1);
        chk_sig("stray_done_irq", 32'(bif.irq), 32'd0);
        wr_reg(OFF_IPEND, 32'hF);
        chk_reg("w1c_all", OFF_IPEND, 32'd0);

        // W1C colliding with an edge-detect set.
        bif.ext_irq = 3'b000;
        step(4);
        bif.ext_irq = 3'b001;
        step(2);
        wr_reg(OFF_IPEND, 32'h2);
        chk_reg("collide_set_wins", OFF_IPEND, 32'h2);
        wr_reg(OFF_IPEND, 32'h2);
        chk_reg("collide_clear", OFF_IPEND, 32'd0);

        // Reset in the middle of a signalled request.
        wr_reg(OFF_IMASK, 32'hF);
        bif.ext_irq = 3'b011;
        step(4);
        chk_sig("pre_rst_irq", 32'(bif.irq), 32'd1);
        chk_sig("pre_rst_id", 32'(bif.irq_id), 32'd2);
        reset = 1'b0;
        bif.ext_irq = 3'b000;
        #1;
        chk_sig("mid_rst_irq", 32'(bif.irq), 32'd0);
        chk_sig("mid_rst_id", 32'(bif.irq_id), 32'd0);
        chk_reg("mid_rst_pend", OFF_IPEND, 32'd0);
        chk_reg("mid_rst_mask", OFF_IMASK, 32'd0);
        step(1);
        reset = 1'b1;
        step(2);
        chk_sig("post_rst_irq", 32'(bif.irq), 32'd0);
        chk_reg("post_rst_isrc", OFF_ISRC, 32'd0);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
